// File: rtl/ander_unit.sv
// ander_unit: bitwise AND with combinational output and registered result, zero/ones flags and popcount
module ander_unit #(
    parameter int SIZE = 8,
    localparam int CW = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] in1,
    input  logic [SIZE-1:0] in2,
    input  logic            in_valid,
    output logic [SIZE-1:0] out,
    output logic [SIZE-1:0] out_q,
    output logic            out_valid,
    output logic            zero_q,
    output logic            ones_q,
    output logic [CW-1:0]   popcnt_q
);
    logic          valid_q;
    logic          zero_d;
    logic          ones_d;
    logic [CW-1:0] popcnt_d;
    assign out       = in1 & in2;
    assign out_valid = valid_q;
    assign zero_d    = (out == '0);
    assign ones_d    = &out;
    always_comb begin
        popcnt_d = '0;
        for (int i = 0; i < SIZE; i++) popcnt_d = popcnt_d + CW'(out[i]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            ones_q   <= 1'b0;
            popcnt_q <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q    <= out;
                zero_q   <= zero_d;
                ones_q   <= ones_d;
                popcnt_q <= popcnt_d;
            end
        end
    end
endmodule

// File: tb/tb_ander_unit.sv
// tb_ander_unit: directed vectors with literal checks plus a per-cycle reference model for the 8-bit unit
module tb_ander_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a8, b8, o8, q8;
    logic        v8, ov8, z8, n8;
    logic [3:0]  p8;
    logic [15:0] a16, b16, o16, q16;
    logic        v16, ov16, z16, n16;
    logic [4:0]  p16;
    logic        a1, b1, o1, q1, v1, ov1, z1, n1;
    logic [0:0]  p1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ander_unit #(.SIZE(8)) u8 (.clk(clk), .rst(rst), .in1(a8), .in2(b8), .in_valid(v8), .out(o8),
        .out_q(q8), .out_valid(ov8), .zero_q(z8), .ones_q(n8), .popcnt_q(p8));
    ander_unit #(.SIZE(16)) u16 (.clk(clk), .rst(rst), .in1(a16), .in2(b16), .in_valid(v16), .out(o16),
        .out_q(q16), .out_valid(ov16), .zero_q(z16), .ones_q(n16), .popcnt_q(p16));
    ander_unit #(.SIZE(1)) u1 (.clk(clk), .rst(rst), .in1(a1), .in2(b1), .in_valid(v1), .out(o1),
        .out_q(q1), .out_valid(ov1), .zero_q(z1), .ones_q(n1), .popcnt_q(p1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the 8-bit unit: the last accepted result and what it implies
    logic       m_known = 1'b0;
    logic [7:0] m_res;
    logic       m_v, m_z, m_o;
    int         m_p;
    always @(posedge clk) begin
        if (rst) begin
            m_known <= 1'b1;
            m_res   <= 8'h00;
            m_v     <= 1'b0;
            m_z     <= 1'b0;
            m_o     <= 1'b0;
            m_p     <= 0;
        end else begin
            m_v <= v8;
            if (v8) begin
                m_res <= a8 & b8;
                m_z   <= ((a8 & b8) == 8'h00);
                m_o   <= ((a8 & b8) == 8'hFF);
                m_p   <= $countones(a8 & b8);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_out", 32'(o8), 32'(a8 & b8));
        if (m_known) begin
            chk("model_out_q", 32'(q8), 32'(m_res));
            chk("model_valid", 32'(ov8), 32'(m_v));
            chk("model_zero", 32'(z8), 32'(m_z));
            chk("model_ones", 32'(n8), 32'(m_o));
            chk("model_pop", 32'(p8), 32'(m_p));
        end
    end

    logic [7:0] tv_a [4] = '{8'h12, 8'hF0, 8'h55, 8'h81};
    logic [7:0] tv_b [4] = '{8'h34, 8'hFF, 8'hAA, 8'hC3};
    logic [7:0] tv_r [4] = '{8'h10, 8'hF0, 8'h00, 8'h81};

    initial begin
        rst = 1'b1; v8 = 1'b0; v16 = 1'b0; v1 = 1'b0;
        a16 = 16'h0; b16 = 16'h0; a1 = 1'b0; b1 = 1'b0;
        a8 = 8'hAA; b8 = 8'hCC;
        #1 chk("comb_aa_cc", 32'(o8), 32'h88);
        a8 = 8'hFF; b8 = 8'h00;
        #1 chk("comb_ff_00", 32'(o8), 32'h00);
        step();
        chk("rst_out_q", 32'(q8), 32'h0);
        chk("rst_valid", 32'(ov8), 32'h0);
        chk("rst_pop", 32'(p8), 32'h0);
        rst = 1'b0;
        v8 = 1'b1; a8 = 8'hAA; b8 = 8'hCC;
        v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h00FF;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        step();
        chk("cap_out_q", 32'(q8), 32'h88);
        chk("cap_pop", 32'(p8), 32'd2);
        chk("cap_zero", 32'(z8), 32'h0);
        chk("cap_ones", 32'(n8), 32'h0);
        chk("cap_valid", 32'(ov8), 32'h1);
        chk("w16_out", 32'(o16), 32'h00FF);
        chk("w16_pop", 32'(p16), 32'd8);
        chk("w16_out_q", 32'(q16), 32'h00FF);
        chk("w1_ones", 32'(n1), 32'h1);
        chk("w1_zero", 32'(z1), 32'h0);
        chk("w1_pop", 32'(p1), 32'h1);
        a8 = 8'hFF; b8 = 8'hFF; b1 = 1'b0; v16 = 1'b0;
        step();
        chk("ones_flag", 32'(n8), 32'h1);
        chk("ones_pop", 32'(p8), 32'd8);
        chk("ones_zero", 32'(z8), 32'h0);
        chk("w1_zero2", 32'(z1), 32'h1);
        chk("w1_ones2", 32'(n1), 32'h0);
        chk("w16_hold", 32'(q16), 32'h00FF);
        chk("w16_novalid", 32'(ov16), 32'h0);
        a8 = 8'hF0; b8 = 8'h0F; v1 = 1'b0;
        step();
        chk("zero_flag", 32'(z8), 32'h1);
        chk("zero_pop", 32'(p8), 32'd0);
        chk("zero_ones", 32'(n8), 32'h0);
        a8 = 8'h3C; b8 = 8'hFF;
        step();
        chk("hold_cap", 32'(q8), 32'h3C);
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #1 chk("hold_comb", 32'(o8), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_out_q", 32'(q8), 32'h3C);
            chk("hold_valid", 32'(ov8), 32'h0);
            chk("hold_pop", 32'(p8), 32'd4);
        end
        rst = 1'b1; v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        step();
        chk("rprio_out_q", 32'(q8), 32'h0);
        chk("rprio_valid", 32'(ov8), 32'h0);
        chk("rprio_zero", 32'(z8), 32'h0);
        chk("rprio_ones", 32'(n8), 32'h0);
        chk("rprio_pop", 32'(p8), 32'h0);
        chk("rprio_comb", 32'(o8), 32'hFF);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a8 = tv_a[i]; b8 = tv_b[i];
            step();
            chk("b2b_out_q", 32'(q8), 32'(tv_r[i]));
            chk("b2b_valid", 32'(ov8), 32'h1);
        end
        v8 = 1'b0;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
